// File: rtl/prod_accum.sv
// -----------------------------------------------------------------------------
// prod_accum
//
// Multiply-accumulate back end for the 8x8 array multiplier. It sums unsigned
// 16-bit products over a frame delimited by in_last. It then presents the frame
// total, the beat count and an overflow flag on a registered valid/ready output.
//
// Optional feature (compile-time macro):
//   PROD_ACCUM_SATURATE_EN - defined: the accumulator clamps at 2^ACC_W-1 on
//                            carry-out and stays clamped for the rest of the
//                            frame. Undefined: the accumulator wraps modulo
//                            2^ACC_W. In both cases out_ovf flags the event.
// -----------------------------------------------------------------------------
module prod_accum #(
  parameter int ACC_W = 24,  // accumulator / sum width, >= 16
  parameter int CNT_W = 8    // beat-counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef PROD_ACCUM_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
`endif

  // Control and running frame state.
  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Result registers driving the output port; loaded on the last beat only.
  logic [ACC_W-1:0] res_sum_q, res_sum_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             res_ovf_q, res_ovf_d;

  // Frame state after the beat on in_prod has been added.
  logic [ACC_W:0]   add_full;
  logic             carry;
  logic [ACC_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             ovf_upd;
  logic             beat_acc;
  logic             out_hs;

  // The extra top bit of the adder captures the carry out of the accumulator.
  assign add_full = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, in_prod};
  assign carry    = add_full[ACC_W];

`ifdef PROD_ACCUM_SATURATE_EN
  // Once a frame has overflowed it stays pinned at full scale.
  assign acc_upd = (ovf_q || carry) ? ACC_MAX : add_full[ACC_W-1:0];
`else
  assign acc_upd = add_full[ACC_W-1:0];
`endif

  assign cnt_upd  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign ovf_upd  = ovf_q | carry;

  // The ready and valid outputs are decoded from the state flop alone. There is
  // no path from out_ready or in_valid. in_ready is also held low while reset
  // is asserted.
  assign in_ready  = (state_q == ST_ACCUM) && !rst;
  assign out_valid = (state_q == ST_HOLD);
  assign beat_acc  = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  assign out_sum   = res_sum_q;
  assign out_count = res_cnt_q;
  assign out_ovf   = res_ovf_q;

  // Next-state decode: clr wins, then beat acceptance (ACCUM) or the result
  // handshake (HOLD).
  always_comb begin
    // NOTE: every signal assigned here gets a default first. That way no path
    // leaves one unassigned and infers a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_sum_d = res_sum_q;
    res_cnt_d = res_cnt_q;
    res_ovf_d = res_ovf_q;

    if (clr) begin
      // Abort: drop any beat and any pending result this cycle.
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == ST_ACCUM) begin
      if (beat_acc) begin
        acc_d = acc_upd;
        cnt_d = cnt_upd;
        ovf_d = ovf_upd;
        if (in_last) begin
          // The result includes the last beat itself.
          res_sum_d = acc_upd;
          res_cnt_d = cnt_upd;
          res_ovf_d = ovf_upd;
          state_d   = ST_HOLD;
        end
      end
    end else begin
      if (out_hs) begin
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = ST_ACCUM;
      end
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // here samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_sum_q <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_sum_q <= res_sum_d;
      res_cnt_q <= res_cnt_d;
      res_ovf_q <= res_ovf_d;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// -----------------------------------------------------------------------------
// tb_prod_accum
//
// Directed vector table plus hand-written overflow sequence plus randomized
// traffic checked against a frame-level reference model (queue of accepted
// products, totals computed arithmetically). Honours PROD_ACCUM_SATURATE_EN.
// -----------------------------------------------------------------------------
module tb_prod_accum;

  localparam int ACC_W = 24;
  localparam int CNT_W = 8;
  localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 1;
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, clr, in_valid, in_last, out_ready;
  logic [15:0]      in_prod;
  logic             in_ready, out_valid, out_ovf;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  int n_checks = 0;
  int n_errors = 0;

  prod_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  // One directed vector: inputs held across one rising edge, outputs expected
  // just after it. Data fields are compared only when chk_data is set.
  typedef struct {
    logic             rst, clr, valid;
    logic [15:0]      prod;
    logic             last, oready;
    logic             e_valid, e_ready, chk_data;
    logic [ACC_W-1:0] e_sum;
    logic [CNT_W-1:0] e_cnt;
    logic             e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int r, c, v, p, l, o, ev, er, cd, es, ec, eo);
    vec_t t;
    t.rst = r[0]; t.clr = c[0]; t.valid = v[0]; t.prod = p[15:0];
    t.last = l[0]; t.oready = o[0];
    t.e_valid = ev[0]; t.e_ready = er[0]; t.chk_data = cd[0];
    t.e_sum = es[ACC_W-1:0]; t.e_cnt = ec[CNT_W-1:0]; t.e_ovf = eo[0];
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, c, v, input logic [15:0] p, input logic l, o);
    rst = r; clr = c; in_valid = v; in_prod = p; in_last = l; out_ready = o;
  endtask

  // ---------------- reference model (frame level) ----------------
  bit               m_hold = 1'b0;
  longint unsigned  m_q[$];
  logic [ACC_W-1:0] m_sum = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_ovf = 1'b0;

  function automatic void model_close_frame();
    longint unsigned total = 0;
    foreach (m_q[i]) total += m_q[i];
    m_ovf = (total > ACC_MAX);
`ifdef PROD_ACCUM_SATURATE_EN
    m_sum = m_ovf ? ACC_W'(ACC_MAX) : ACC_W'(total);
`else
    m_sum = ACC_W'(total);  // modulo 2^ACC_W
`endif
    m_cnt = (longint'(m_q.size()) > longint'(CNT_MAX)) ? CNT_W'(CNT_MAX) : CNT_W'(m_q.size());
  endfunction

  // Called at the rising edge with the inputs that edge samples.
  function automatic void model_step();
    if (rst) begin
      m_hold = 1'b0; m_q.delete(); m_sum = '0; m_cnt = '0; m_ovf = 1'b0;
    end else if (clr) begin
      m_hold = 1'b0; m_q.delete();
    end else if (!m_hold) begin
      if (in_valid) begin
        m_q.push_back(longint'(in_prod));
        if (in_last) begin
          model_close_frame();
          m_hold = 1'b1;
        end
      end
    end else if (out_ready) begin
      m_hold = 1'b0; m_q.delete();
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " out_valid"}, 64'(out_valid), 64'(m_hold));
    check({tag, " in_ready"}, 64'(in_ready), 64'(!m_hold && !rst));
    if (m_hold) begin
      check({tag, " out_sum"}, 64'(out_sum), 64'(m_sum));
      check({tag, " out_count"}, 64'(out_count), 64'(m_cnt));
      check({tag, " out_ovf"}, 64'(out_ovf), 64'(m_ovf));
    end
  endtask

  initial begin
    logic [ACC_W-1:0] ovf_exp_sum;
    int               last_mode;

    drive(1, 0, 0, 16'h0, 0, 0);

    // ---------------- directed vector table ----------------
    // reset, then the first idle cycle after it
    vecs.push_back(mk(1,0,0,0,0,0,       0,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,       0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,       0,1,1,0,0,0));
    // single beat frame
    vecs.push_back(mk(0,0,1,'h3039,1,0,  1,0,1,'h3039,1,0));
    vecs.push_back(mk(0,0,0,0,0,1,       0,1,0,0,0,0));
    // backpressure: result held and in_ready low for 5 cycles
    vecs.push_back(mk(0,0,1,'h0001,0,0,  0,1,0,0,0,0));
    vecs.push_back(mk(0,0,1,'h00FF,0,0,  0,1,0,0,0,0));
    vecs.push_back(mk(0,0,1,'hFE01,1,0,  1,0,1,'hFF01,3,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,1,'h1234,0,0, 1,0,1,'hFF01,3,0));
    vecs.push_back(mk(0,0,0,0,0,1,       0,1,0,0,0,0));
    // clr discards the partial frame and the beat presented with it
    vecs.push_back(mk(0,0,1,'h0010,0,0,  0,1,0,0,0,0));
    vecs.push_back(mk(0,0,1,'h0020,0,0,  0,1,0,0,0,0));
    vecs.push_back(mk(0,1,1,'h0040,0,0,  0,1,0,0,0,0));
    vecs.push_back(mk(0,0,1,'h0005,1,0,  1,0,1,'h0005,1,0));
    vecs.push_back(mk(0,0,0,0,0,1,       0,1,0,0,0,0));
    // clr while holding a result drops it
    vecs.push_back(mk(0,0,1,'h0007,1,0,  1,0,1,'h0007,1,0));
    vecs.push_back(mk(0,1,0,0,0,0,       0,1,0,0,0,0));
    vecs.push_back(mk(0,0,1,'h0009,1,0,  1,0,1,'h0009,1,0));
    vecs.push_back(mk(0,0,0,0,0,1,       0,1,0,0,0,0));
    // reset while in HOLD
    vecs.push_back(mk(0,0,1,'h0100,1,0,  1,0,1,'h0100,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,       0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,       0,1,1,0,0,0));
    // reset mid-frame
    vecs.push_back(mk(0,0,1,'h0050,0,0,  0,1,0,0,0,0));
    vecs.push_back(mk(1,0,1,'h0060,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk(0,0,1,'h0070,1,0,  1,0,1,'h0070,1,0));
    vecs.push_back(mk(0,0,0,0,0,1,       0,1,0,0,0,0));
    // back-to-back frames with out_ready tied high; beat 4 waits out HOLD
    vecs.push_back(mk(0,0,1,'h0002,0,1,  0,1,0,0,0,0));
    vecs.push_back(mk(0,0,1,'h0003,1,1,  1,0,1,'h0005,2,0));
    vecs.push_back(mk(0,0,1,'h0004,1,1,  0,1,0,0,0,0));
    vecs.push_back(mk(0,0,1,'h0004,1,1,  1,0,1,'h0004,1,0));
    vecs.push_back(mk(0,0,0,0,0,1,       0,1,0,0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].valid, vecs[i].prod, vecs[i].last, vecs[i].oready);
      tick();
      check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_ready));
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d out_sum", i), 64'(out_sum), 64'(vecs[i].e_sum));
        check($sformatf("vec%0d out_count", i), 64'(out_count), 64'(vecs[i].e_cnt));
        check($sformatf("vec%0d out_ovf", i), 64'(out_ovf), 64'(vecs[i].e_ovf));
      end
    end

    // ---------------- overflow: 257 beats of 0xFFFF ----------------
    // 257 * 0xFFFF = 0x100FEFF; the count saturates at 255.
`ifdef PROD_ACCUM_SATURATE_EN
    ovf_exp_sum = 24'hFFFFFF;
`else
    ovf_exp_sum = 24'h00FEFF;
`endif
    for (int i = 0; i < 257; i++) begin
      drive(0, 0, 1, 16'hFFFF, (i == 256), 0);
      tick();
    end
    check("ovf out_valid", 64'(out_valid), 64'd1);
    check("ovf out_count", 64'(out_count), 64'd255);
    check("ovf out_ovf", 64'(out_ovf), 64'd1);
    check("ovf out_sum", 64'(out_sum), 64'(ovf_exp_sum));
    drive(0, 0, 0, 16'h0, 0, 0);
    tick();
    check("ovf hold out_sum", 64'(out_sum), 64'(ovf_exp_sum));
    check("ovf hold in_ready", 64'(in_ready), 64'd0);
    drive(0, 0, 0, 16'h0, 0, 1);
    tick();
    check("ovf release out_valid", 64'(out_valid), 64'd0);
    check("ovf release in_ready", 64'(in_ready), 64'd1);

    // ---------------- randomized traffic vs reference model ----------------
    drive(1, 0, 0, 16'h0, 0, 0);
    tick();
    check_model("rnd reset");
    last_mode = 4;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 500 == 0) last_mode = (cyc % 1000 == 0) ? 4 : 40;
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 9) < 7,
            16'($urandom()),
            $urandom_range(0, last_mode - 1) == 0,
            $urandom_range(0, 2) != 0);
      tick();
      check_model($sformatf("rnd%0d", cyc));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
# prod_accum

Accumulator stage directly downstream of the 8x8 array multiplier. It consumes the 16-bit product stream under a valid/ready handshake and sums products into a wide register across a frame delimited by `in_last`. It then presents the frame total, beat count and overflow flag on a registered valid/ready output. It turns the purely combinational multiplier into a dot-product / multiply-accumulate datapath.

## Interface
Parameters:
- `ACC_W`, 24: accumulator and output sum width; must be ≥ 16.
- `CNT_W`, 8: beat-counter width.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `clr` in 1: synchronous frame abort/clear, active-high.
- `in_valid` in 1: product beat valid.
- `in_ready` out 1: stage accepts a beat this cycle.
- `in_prod` in 16: unsigned product, as produced by the multiplier.
- `in_last` in 1: final beat of frame, qualified by `in_valid`.
- `out_valid` out 1: frame result valid.
- `out_ready` in 1: downstream accepts result.
- `out_sum` out ACC_W: frame total.
- `out_count` out CNT_W: accepted beats in frame.
- `out_ovf` out 1: sum exceeded 2^ACC_W−1 during the frame.

## Operation
- Two states: ACCUM and HOLD. Reset enters ACCUM.
- ACCUM behaviour:
  - `in_ready`=1 and `out_valid`=0.
  - A beat is accepted when `in_valid & in_ready`.
  - On acceptance: acc ← acc + zero-extended `in_prod`; count ← count+1, saturating at 2^CNT_W−1.
  - A carry out of bit ACC_W−1 sets sticky ovf.
- Accepting a beat with `in_last`=1:
  - The same update applies, including that beat.
  - Result registers load the updated acc/count/ovf.
  - State → HOLD.
- HOLD behaviour:
  - `in_ready`=0 and `out_valid`=1.
  - `out_sum`, `out_count` and `out_ovf` are stable until the handshake.
- On `out_valid & out_ready`:
  - acc, count and ovf clear to 0.
  - State → ACCUM.
- `clr` has priority over every other input in either state:
  - acc, count and ovf clear to 0; state → ACCUM.
  - Any beat presented that cycle is discarded.
  - An output handshake in that cycle is not counted as a new frame; the result is dropped.
- Arithmetic is unsigned throughout. `in_prod` is never sign-extended.
- Frames of any length ≥ 1 are legal. A zero-length frame is impossible, since `in_last` rides on a data beat.

## Timing
- While `rst`=1 and on the first cycle after it, all outputs read:
  - `in_ready`=0 during the `rst` cycle, 1 afterwards.
  - `out_valid`=0.
  - `out_sum`=0, `out_count`=0, `out_ovf`=0.
- `in_ready` is a function of state only. It has no combinational path from `out_ready`.
- Latency: the last beat is accepted at edge N; `out_valid`=1 and the result is visible from edge N through the handshake edge.
- Throughput: one beat per cycle in ACCUM. One dead input cycle per frame, the HOLD cycle; that is a minimum when `out_ready`=1.
- `rst` asserted mid-frame or in HOLD discards all state at that edge.

## Configuration
- `PROD_ACCUM_SATURATE_EN` defined:
  - On carry out of the accumulator, acc clamps to 2^ACC_W−1 and stays clamped for the rest of the frame.
  - `out_ovf`=1.
- Not defined:
  - Acc wraps modulo 2^ACC_W.
  - `out_ovf`=1 still flags the wrap.

## Test plan
- Single beat:
  - Stimulus: `in_prod`=0x3039 with `in_last`=1.
  - Required response, next cycle: `out_valid`=1, `out_sum`=0x003039, `out_count`=1, `out_ovf`=0.
  - Handshake returns to ACCUM with `in_ready`=1.
- Backpressure:
  - Stimulus: three beats 0x0001, 0x00FF, 0xFE01 (last), then `out_ready`=0 for 5 cycles.
  - Required response: `out_sum`=0x00FF01 and `out_count`=3 held stable; `in_ready`=0 throughout.
  - Release `out_ready` → `out_valid` drops next cycle.
- Overflow, ACC_W=24, CNT_W=8:
  - Stimulus: 257 beats of 0xFFFF.
  - Required response: `out_count`=255 (saturated), `out_ovf`=1.
  - `out_sum`=0x00FEFF without `PROD_ACCUM_SATURATE_EN`; 0xFFFFFF with it.
- Clear:
  - Stimulus: beats 0x0010, 0x0020; then `clr`=1 together with `in_valid`=1 and `in_prod`=0x0040; then 0x0005 (last).
  - Required response: `out_sum`=0x000005, `out_count`=1.
- Reset in HOLD:
  - Stimulus: complete a frame, leave `out_ready`=0, assert `rst` for 1 cycle.
  - Required response: `out_valid`=0 and `out_sum`=0 after the edge; `in_ready`=1 on the following cycle.
- Back-to-back frames:
  - Stimulus: `out_ready` tied 1; frames {2,3 last} and {4 last} presented continuously.
  - Required response: results 5/count 2, then 4/count 1, with exactly one `in_ready`=0 cycle between frames.
